fetch_target_queue: RTL

Fetch target queue (FTQ) that sequences branch-prediction blocks from the BPU into the icache and back out to the predictor update path. It holds each `BPInfo_t` from enqueue until the backend commits it, and issues fetch requests (`ftq2icacheInfo_t`) in program order. On commit it emits one `BPupdateInfo_t` per block, and on redirect it squashes younger blocks. It sits between the BPU (uBTB/FTB) and the icache/backend.

---
 rtl/fetch_target_queue_pkg.sv | 61 ++++++
 rtl/fetch_target_queue_ftq_storage.sv | 28 ++
 rtl/fetch_target_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_target_queue_pkg.sv
// Shared types for the fetch target queue: BPU block, icache request, predictor update.
// Optional same-cycle BPU-to-icache bypass is enabled by defining FTQ_BYPASS_EN.
package fetch_target_queue_pkg;

  localparam int FTQ_DEPTH         = 8;
  localparam int XLEN              = 32;
  localparam int FTB_PREDICT_WIDTH = 16;
  // One extra bit so a full-width block (size == FTB_PREDICT_WIDTH) is representable.
  localparam int FETCH_SIZE_W      = $clog2(FTB_PREDICT_WIDTH) + 1;

  typedef logic [XLEN-1:0] xdef_t;
  typedef logic [$clog2(FTQ_DEPTH):0] ftq_idx_t;

  typedef enum logic [1:0] {
    BR_NONE     = 2'd0,
    BR_COND     = 2'd1,
    BR_DIRECT   = 2'd2,
    BR_INDIRECT = 2'd3
  } branch_type_t;

  typedef struct packed {
    xdef_t start_addr;
    xdef_t end_addr;
    xdef_t next_addr;
    logic  taken;
    logic  hit_on_ubtb;
    logic  hit_on_ftb;
  } bp_info_t;

  typedef struct packed {
    xdef_t                   start_addr;
    xdef_t                   next_addr;
    logic                    taken;
    logic [FETCH_SIZE_W-1:0] fetch_block_size;
  } ftq2icache_info_t;

  typedef struct packed {
    xdef_t        start_addr;
    xdef_t        fallthru_addr;
    xdef_t        target_addr;
    branch_type_t branch_type;
    logic         taken;
    logic         mispred;
    logic         hit_on_ubtb;
    logic         hit_on_ftb;
  } bp_update_info_t;

  localparam int BP_INFO_W     = $bits(bp_info_t);
  localparam int FETCH_INFO_W  = $bits(ftq2icache_info_t);
  localparam int UPDATE_INFO_W = $bits(bp_update_info_t);

  function automatic ftq2icache_info_t to_fetch_info(input bp_info_t e);
    ftq2icache_info_t f;
    f.start_addr       = e.start_addr;
    f.next_addr        = e.next_addr;
    f.taken            = e.taken;
    f.fetch_block_size = FETCH_SIZE_W'(e.end_addr - e.start_addr);
    return f;
  endfunction

endpackage

// File: rtl/fetch_target_queue_ftq_storage.sv
// Entry array for the fetch target queue: one write port, two asynchronous read ports
// (fetch head and commit head). Contents are intentionally not reset.
module fetch_target_queue_ftq_storage #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_fetch,
  output logic [WIDTH-1:0]         rdata_fetch,
  input  logic [$clog2(DEPTH)-1:0] raddr_cmt,
  output logic [WIDTH-1:0]         rdata_cmt
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_fetch = mem[raddr_fetch];
  assign rdata_cmt   = mem[raddr_cmt];

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: holds BPU blocks from enqueue to commit, issues icache requests in order,
// emits one predictor update per committed block. FTQ_BYPASS_EN adds a same-cycle empty-queue fetch path.
//
// Handshakes: a transfer happens in a cycle where both vld and rdy are high at the rising clock edge;
// vld/payload must not depend on rdy of the same channel, and a producer holds vld/payload until accepted.
module fetch_target_queue
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH = FTQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_bp_vld,
  output logic                     o_bp_rdy,
  input  logic [BP_INFO_W-1:0]     i_bp_info,
  output logic                     o_fetch_vld,
  input  logic                     i_fetch_rdy,
  output logic [FETCH_INFO_W-1:0]  o_fetch_info,
  output logic [$clog2(DEPTH):0]   o_fetch_idx,
  input  logic                     i_commit_vld,
  output logic                     o_commit_rdy,
  input  logic                     i_commit_taken,
  input  logic                     i_commit_mispred,
  input  logic [XLEN-1:0]          i_commit_target,
  input  logic [1:0]               i_commit_btype,
  output logic                     o_update_vld,
  input  logic                     i_update_rdy,
  output logic [UPDATE_INFO_W-1:0] o_update_info,
  input  logic                     i_redirect_vld,
  input  logic [$clog2(DEPTH):0]   i_redirect_idx
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] enq_ptr, fetch_ptr, cmt_ptr;
  logic [PW-1:0] enq_next, fetch_next, cmt_next;
  logic [PW-1:0] count, redir_next, fetch_off, redir_off, redir_rel;
  logic          full, fetch_empty, redir_legal;
  logic          bp_fire, fetch_fire, commit_fire;
  logic          update_vld;
  bp_info_t        fetch_entry, cmt_entry;
  bp_update_info_t update_info, update_next;
  logic [BP_INFO_W-1:0] fetch_raw, cmt_raw;

  fetch_target_queue_ftq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (BP_INFO_W)
  ) u_storage (
    .clk         (clk),
    .we          (bp_fire),
    .waddr       (enq_ptr[IW-1:0]),
    .wdata       (i_bp_info),
    .raddr_fetch (fetch_ptr[IW-1:0]),
    .rdata_fetch (fetch_raw),
    .raddr_cmt   (cmt_ptr[IW-1:0]),
    .rdata_cmt   (cmt_raw)
  );

  assign fetch_entry = fetch_raw;
  assign cmt_entry   = cmt_raw;

  // Occupancy from registered pointers only, so a same-cycle commit never frees a slot early.
  assign count       = enq_ptr - cmt_ptr;
  assign full        = (count == PW'(DEPTH));
  assign fetch_empty = (fetch_ptr == enq_ptr);

  assign o_bp_rdy = !full && !i_redirect_vld;
  assign bp_fire  = i_bp_vld && o_bp_rdy;

`ifdef FTQ_BYPASS_EN
  bp_info_t bp_in;
  logic     bypass;
  logic     unused_bypass_bits;

  assign bp_in              = i_bp_info;
  assign bypass             = fetch_empty && bp_fire;
  assign o_fetch_vld        = !fetch_empty || bypass;
  assign o_fetch_info       = bypass ? to_fetch_info(bp_in) : to_fetch_info(fetch_entry);
  assign unused_bypass_bits = ^{bp_in.hit_on_ubtb, bp_in.hit_on_ftb};
`else
  assign o_fetch_vld  = !fetch_empty;
  assign o_fetch_info = to_fetch_info(fetch_entry);
`endif

  assign o_fetch_idx = fetch_ptr;
  assign fetch_fire  = o_fetch_vld && i_fetch_rdy;

  assign o_commit_rdy = (cmt_ptr != fetch_ptr) && (!update_vld || i_update_rdy);
  assign commit_fire  = i_commit_vld && o_commit_rdy;

  // Redirect bookkeeping measured as distances from cmt, which makes the compare wrap-safe.
  assign redir_next  = i_redirect_idx + PW'(1);
  assign fetch_off   = fetch_ptr - cmt_ptr;
  assign redir_off   = redir_next - cmt_ptr;
  assign redir_rel   = i_redirect_idx - cmt_ptr;
  assign redir_legal = (redir_rel < count);

  always_comb begin
    enq_next   = enq_ptr;
    fetch_next = fetch_ptr;
    cmt_next   = cmt_ptr;
    if (commit_fire) begin
      cmt_next = cmt_ptr + PW'(1);
    end
    if (i_redirect_vld) begin
      enq_next = redir_next;
      if (fetch_off > redir_off) begin
        fetch_next = redir_next;
      end
    end else begin
      if (bp_fire) begin
        enq_next = enq_ptr + PW'(1);
      end
      if (fetch_fire) begin
        fetch_next = fetch_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_ptr   <= '0;
      fetch_ptr <= '0;
      cmt_ptr   <= '0;
    end else begin
      enq_ptr   <= enq_next;
      fetch_ptr <= fetch_next;
      cmt_ptr   <= cmt_next;
    end
  end

  always_comb begin
    update_next               = update_info;
    update_next.start_addr    = cmt_entry.start_addr;
    update_next.fallthru_addr = cmt_entry.end_addr;
    update_next.target_addr   = i_commit_target;
    update_next.branch_type   = branch_type_t'(i_commit_btype);
    update_next.taken         = i_commit_taken;
    update_next.mispred       = i_commit_mispred;
    update_next.hit_on_ubtb   = cmt_entry.hit_on_ubtb;
    update_next.hit_on_ftb    = cmt_entry.hit_on_ftb;
  end

  // A new commit while the previous update is being accepted keeps vld high with fresh fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_vld  <= 1'b0;
      update_info <= '0;
    end else if (commit_fire) begin
      update_vld  <= 1'b1;
      update_info <= update_next;
    end else if (i_update_rdy) begin
      update_vld  <= 1'b0;
    end
  end

  assign o_update_vld  = update_vld;
  assign o_update_info = update_info;

  logic unused_entry_bits;
  assign unused_entry_bits = ^{fetch_entry.hit_on_ubtb, fetch_entry.hit_on_ftb,
                               cmt_entry.next_addr, cmt_entry.taken};

  a_redirect_in_window: assert property (@(posedge clk) disable iff (rst)
    i_redirect_vld |-> redir_legal);

endmodule
